// File: rtl/hdc_pkg.sv
// Shared HDC constants, chunk index width helper and streamer FSM states.
package hdc_pkg;

   localparam int NUM_CLASSES_D = 26;
   localparam int HV_DIM_D      = 4096;
   localparam int DIMS_PER_CC_D = 1024;

   function automatic int chunk_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

endpackage

// File: rtl/chunk_skip_finder.sv
// Finds the lowest eligible chunk at or above cur and whether it is the
// highest eligible chunk of the run.
module chunk_skip_finder #(
   parameter int SEQ = 4,
   parameter int W   = 2
) (
   input  logic [SEQ-1:0] nz,
   input  logic [W-1:0]   cur,
   input  logic           skip_pruned,
   output logic [W-1:0]   nxt,
   output logic           found,
   output logic           last
);

   logic [SEQ-1:0] elig;

   always_comb begin
      elig  = skip_pruned ? nz : '1;
      nxt   = '0;
      found = 1'b0;
      last  = 1'b1;
      for (int i = SEQ - 1; i >= 0; i--) begin
         if (elig[i] && (i >= int'(cur))) begin
            nxt   = W'(i);
            found = 1'b1;
         end
      end
      for (int i = 0; i < SEQ; i++) begin
         if (elig[i] && (i > int'(nxt))) last = 1'b0;
      end
   end

endmodule

// File: rtl/class_hv_streamer.sv
// Streams class hypervectors chunk by chunk, transposed per dimension,
// with pruning mask applied and optional skipping of fully pruned chunks.
module class_hv_streamer
   import hdc_pkg::*;
#(
   parameter int NUM_CLASSES = NUM_CLASSES_D,
   parameter int HV_DIM      = HV_DIM_D,
   parameter int DIMS_PER_CC = DIMS_PER_CC_D
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic abort,
   input  logic skip_pruned,
   input  logic [HV_DIM-1:0] dim_mask,
   input  logic [NUM_CLASSES-1:0][HV_DIM/DIMS_PER_CC-1:0]
                [DIMS_PER_CC-1:0] class_hvs,
   input  logic out_ready,
   output logic out_valid,
   output logic [DIMS_PER_CC-1:0][NUM_CLASSES-1:0] out_per_dim,
   output logic [chunk_w(HV_DIM/DIMS_PER_CC)-1:0] out_chunk_idx,
   output logic out_last,
   output logic busy,
   output logic done
);

   localparam int SEQ = HV_DIM / DIMS_PER_CC;
   localparam int CW  = chunk_w(SEQ);

   state_t state;

   logic [SEQ-1:0][DIMS_PER_CC-1:0] mask2;
   logic [SEQ-1:0]                  nz;
   logic [CW-1:0]                   cur;
   logic [CW-1:0]                   nxt;
   logic                            found;
   logic                            is_last;
   logic [DIMS_PER_CC-1:0][NUM_CLASSES-1:0] beat;

   assign mask2 = dim_mask;
   assign busy  = (state == STREAM);

   always_comb begin
      nz = '0;
      for (int k = 0; k < SEQ; k++) nz[k] = |mask2[k];
   end

   // In STREAM the search resumes just past the chunk currently on the bus.
   assign cur = (state == IDLE) ? '0 : out_chunk_idx + CW'(1);

   chunk_skip_finder #(
      .SEQ(SEQ),
      .W  (CW)
   ) u_finder (
      .nz         (nz),
      .cur        (cur),
      .skip_pruned(skip_pruned),
      .nxt        (nxt),
      .found      (found),
      .last       (is_last)
   );

   always_comb begin
      beat = '0;
      for (int j = 0; j < DIMS_PER_CC; j++) begin
         for (int c = 0; c < NUM_CLASSES; c++) begin
            beat[j][NUM_CLASSES-1-c] = class_hvs[c][nxt][j] & mask2[nxt][j];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         out_valid     <= 1'b0;
         out_last      <= 1'b0;
         out_chunk_idx <= '0;
         out_per_dim   <= '0;
         done          <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (found) begin
                     state         <= STREAM;
                     out_valid     <= 1'b1;
                     out_per_dim   <= beat;
                     out_chunk_idx <= nxt;
                     out_last      <= is_last;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            STREAM: begin
               if (abort) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end else if (out_valid && out_ready) begin
                  if (out_last) begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     out_per_dim   <= beat;
                     out_chunk_idx <= nxt;
                     out_last      <= is_last;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_class_hv_streamer.sv
// Randomized self-checking bench for class_hv_streamer (4 classes, 16 dims, 4 per chunk).
module tb_class_hv_streamer;

   localparam int NC = 4;
   localparam int HD = 16;
   localparam int DC = 4;
   localparam int SQ = 4;
   localparam int CW = 2;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic abort;
   logic skip_pruned;
   logic out_ready;
   logic [HD-1:0] dim_mask;
   logic [NC-1:0][SQ-1:0][DC-1:0] class_hvs;
   logic out_valid;
   logic out_last;
   logic busy;
   logic done;
   logic [DC-1:0][NC-1:0] out_per_dim;
   logic [CW-1:0] out_chunk_idx;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   class_hv_streamer #(
      .NUM_CLASSES(NC),
      .HV_DIM     (HD),
      .DIMS_PER_CC(DC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .skip_pruned  (skip_pruned),
      .dim_mask     (dim_mask),
      .class_hvs    (class_hvs),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .out_per_dim  (out_per_dim),
      .out_chunk_idx(out_chunk_idx),
      .out_last     (out_last),
      .busy         (busy),
      .done         (done)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_hvs();
      for (int c = 0; c < NC; c++)
         for (int k = 0; k < SQ; k++)
            for (int j = 0; j < DC; j++)
               class_hvs[c][k][j] = 1'($urandom_range(0, 1));
   endtask

   // Bit j*NC + (NC-1-c) of the flat beat holds class c, dimension j.
   function automatic logic [15:0] exp_beat(input int k);
      logic [15:0] r;
      r = '0;
      for (int j = 0; j < DC; j++)
         for (int c = 0; c < NC; c++)
            if (dim_mask[k*DC+j]) r[j*NC+(NC-1-c)] = class_hvs[c][k][j];
      return r;
   endfunction

   task automatic do_run(input logic [15:0] m, input logic sk,
                         input int rmode);
      int q[$];
      int n;
      int stall;
      dim_mask    = m;
      skip_pruned = sk;
      rand_hvs();
      for (int k = 0; k < SQ; k++)
         if (!sk || ((m >> (k * DC)) & 16'hF) != 0) q.push_back(k);
      start = 1'b1;
      step();
      start = 1'b0;
      if (q.size() == 0) begin
         check("empty_valid", out_valid, 0);
         check("empty_busy", busy, 0);
         check("empty_done", done, 1);
         return;
      end
      check("run_busy", busy, 1);
      n = 0;
      stall = 0;
      while (q.size() > 0 && n < 100) begin
         check("valid", out_valid, 1);
         check("idx", out_chunk_idx, q[0]);
         check("data", out_per_dim, exp_beat(q[0]));
         check("last", out_last, q.size() == 1);
         check("done_lo", done, 0);
         case (rmode)
            0: out_ready = 1'b1;
            1: begin
               out_ready = (stall >= 3);
               stall++;
            end
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         start = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         step();
         n++;
         if (out_ready) void'(q.pop_front());
      end
      start = 1'b0;
      check("run_bound", n < 100, 1);
      check("end_valid", out_valid, 0);
      check("end_busy", busy, 0);
      check("end_done", done, 1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_last"}, out_last, 0);
      check({tag, "_idx"}, out_chunk_idx, 0);
      check({tag, "_data"}, out_per_dim, 0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      skip_pruned = 1'b0;
      out_ready = 1'b1;
      dim_mask = '0;
      class_hvs = '0;
      step();
      step();
      check_zero("reset");
      rst = 1'b0;
      step();
      check("post_reset_done", done, 0);

      do_run(16'hFFFF, 1'b0, 0);
      step();
      check("idle_done", done, 0);
      do_run(16'h0F0F, 1'b1, 0);
      do_run(16'h00F0, 1'b0, 0);
      do_run(16'hFFFF, 1'b0, 1);
      do_run(16'h0000, 1'b1, 0);
      step();
      check("empty_done_lo", done, 0);
      check("empty_valid_lo", out_valid, 0);

      dim_mask = 16'hFFFF;
      skip_pruned = 1'b0;
      rand_hvs();
      out_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      check("ab_k0", out_chunk_idx, 0);
      step();
      check("ab_k1", out_chunk_idx, 1);
      abort = 1'b1;
      start = 1'b1;
      step();
      abort = 1'b0;
      start = 1'b0;
      check("ab_valid", out_valid, 0);
      check("ab_busy", busy, 0);
      check("ab_done", done, 0);
      step();
      check("ab_done2", done, 0);
      check("ab_valid2", out_valid, 0);

      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      check("rst_k2", out_chunk_idx, 2);
      rst = 1'b1;
      step();
      check_zero("midrst");
      rst = 1'b0;
      step();
      check("midrst_valid", out_valid, 0);
      check("midrst_done", done, 0);
      do_run(16'hFFFF, 1'b0, 0);

      for (int r = 0; r < 40; r++) begin
         do_run(16'($urandom & $urandom), 1'($urandom_range(0, 1)), 2);
         if ($urandom_range(0, 1)) begin
            step();
            check("gap_done", done, 0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
